// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared constants for the instruction fetch sequencer: FSM encodings and
// the IR half-load control values.
package instr_fetch_ctrl_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LO    = 2'd1;
  localparam logic [1:0] S_HI    = 2'd2;
  localparam logic [1:0] S_ISSUE = 2'd3;

  localparam logic [1:0] FUNSEL_LOAD = 2'b01;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/instr_fetch_ctrl_pc_counter.sv
// Program counter: load / advance-by-two / hold, with pc and pc+1 taps
// for the two byte fetches of a 16-bit instruction.
module pc_counter #(
  parameter int unsigned         ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_inc2,
  input  logic [ADDR_W-1:0] i_pc_in,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_plus1
);

  logic [ADDR_W-1:0] r_pc;

  // Load outranks the increment so a redirect never also advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_pc_in;
    end else if (i_inc2) begin
      r_pc <= r_pc + ADDR_W'(2);
    end
  end

  assign o_pc       = r_pc;
  assign o_pc_plus1 = r_pc + ADDR_W'(1);

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: reads a 16-bit instruction as two bytes (PC, PC+1),
// steers them into the IR halves and offers the result to decode.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        ir_i_half,
  output logic [1:0]        ir_funsel,
  output logic              ir_e,
  output logic              ir_l_h,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] pc_out
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [ADDR_W-1:0] w_pc;
  logic [ADDR_W-1:0] w_pc_plus1;
  logic              w_fetching;
  logic              w_inc2;

  pc_counter #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (pc_load),
    .i_inc2    (w_inc2),
    .i_pc_in   (pc_in),
    .o_pc      (w_pc),
    .o_pc_plus1(w_pc_plus1)
  );

  assign w_fetching = (r_state == S_LO) || (r_state == S_HI);
  assign w_inc2     = (r_state == S_ISSUE) && instr_ready && !pc_load;

  always_comb begin
    w_state_next = r_state;
    if (pc_load) begin
      w_state_next = S_LO;
    end else begin
      case (r_state)
        S_IDLE:  w_state_next = S_LO;
        S_LO:    if (mem_ack) w_state_next = S_HI;
        S_HI:    if (mem_ack) w_state_next = S_ISSUE;
        S_ISSUE: if (instr_ready) w_state_next = S_LO;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A redirect in the same cycle as an ack throws that byte away.
  assign mem_req     = w_fetching;
  assign mem_addr    = (r_state == S_HI) ? w_pc_plus1 : w_pc;
  assign ir_i_half   = mem_rdata;
  assign ir_funsel   = FUNSEL_LOAD;
  assign ir_e        = w_fetching && mem_ack && !pc_load;
  assign ir_l_h      = (r_state == S_HI) ? HALF_HI : HALF_LO;
  assign instr_valid = (r_state == S_ISSUE);
  assign pc_out      = w_pc;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios followed by
// random memory wait states, decode back-pressure and redirects.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        instr_ready;
  logic        pc_load;
  logic [15:0] pc_in;

  logic        mem_req, ir_e, ir_l_h, instr_valid;
  logic [15:0] mem_addr, pc_out;
  logic [7:0]  ir_i_half;
  logic [1:0]  ir_funsel;

  logic        mem_req_f, ir_e_f, ir_l_h_f, instr_valid_f;
  logic [15:0] mem_addr_f, pc_out_f;
  logic [7:0]  ir_i_half_f;
  logic [1:0]  ir_funsel_f;

  always #5 clk = ~clk;

  instr_fetch_ctrl #(.ADDR_W(16), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir_i_half(ir_i_half),
    .ir_funsel(ir_funsel), .ir_e(ir_e), .ir_l_h(ir_l_h),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_load(pc_load), .pc_in(pc_in), .pc_out(pc_out)
  );

  instr_fetch_ctrl #(.ADDR_W(16), .RESET_PC(16'hFFFF)) u_dut_ff (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req_f), .mem_addr(mem_addr_f),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir_i_half(ir_i_half_f),
    .ir_funsel(ir_funsel_f), .ir_e(ir_e_f), .ir_l_h(ir_l_h_f),
    .instr_valid(instr_valid_f), .instr_ready(instr_ready),
    .pc_load(pc_load), .pc_in(pc_in), .pc_out(pc_out_f)
  );

  // Byte-wide memory image and a stand-in for the IR fed by the DUT's controls.
  logic [7:0]  mem [65536];
  logic [15:0] ir_q = 16'h0;
  int          e_count = 0;

  always_comb mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (ir_e) begin
      if (ir_l_h) ir_q[15:8] <= ir_i_half;
      else        ir_q[7:0]  <= ir_i_half;
      e_count <= e_count + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: which instruction is being fetched and how many of its bytes
  // have arrived so far.
  logic [15:0] m_pc;
  int          m_nbytes;
  bit          m_idle;

  task automatic model_reset(input logic [15:0] rpc);
    m_pc     = rpc;
    m_nbytes = 0;
    m_idle   = 1'b1;
  endtask

  // Apply one cycle of inputs, check the DUT, then advance the reference.
  task automatic step(input bit a, input bit r, input bit l, input logic [15:0] t);
    bit          exp_req, exp_valid, exp_e;
    logic [15:0] exp_addr;
    mem_ack = a; instr_ready = r; pc_load = l; pc_in = t;
    #1;
    exp_req   = !m_idle && (m_nbytes < 2);
    exp_valid = !m_idle && (m_nbytes == 2);
    exp_e     = exp_req && a && !l;
    exp_addr  = m_pc + 16'(m_nbytes);
    check_eq("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
    if (exp_req) check_eq("mem_addr", {16'b0, mem_addr}, {16'b0, exp_addr});
    check_eq("instr_valid", {31'b0, instr_valid}, {31'b0, exp_valid});
    check_eq("ir_e", {31'b0, ir_e}, {31'b0, exp_e});
    check_eq("ir_l_h", {31'b0, ir_l_h}, {31'b0, exp_req && (m_nbytes == 1)});
    check_eq("ir_funsel", {30'b0, ir_funsel}, 32'h1);
    check_eq("pc_out", {16'b0, pc_out}, {16'b0, m_pc});
    if (exp_e) check_eq("ir_i_half", {24'b0, ir_i_half}, {24'b0, mem[exp_addr]});
    if (exp_valid) check_eq("instr", {16'b0, ir_q}, {16'b0, mem[m_pc + 16'd1], mem[m_pc]});
    if (l) begin
      m_pc = t; m_nbytes = 0; m_idle = 1'b0;
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_nbytes < 2) begin
      if (a) m_nbytes++;
    end else if (r) begin
      m_pc = m_pc + 16'd2; m_nbytes = 0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int e0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h34;
    mem[1] = 8'h12;
    rst_n = 1'b0; mem_ack = 1'b1; instr_ready = 1'b0; pc_load = 1'b0; pc_in = 16'h0;

    // Reset state, with a stray ack present.
    #23;
    check_eq("rst_mem_req", {31'b0, mem_req}, 32'h0);
    check_eq("rst_ir_e", {31'b0, ir_e}, 32'h0);
    check_eq("rst_valid", {31'b0, instr_valid}, 32'h0);
    check_eq("rst_funsel", {30'b0, ir_funsel}, 32'h1);
    check_eq("rst_l_h", {31'b0, ir_l_h}, 32'h0);
    check_eq("rst_pc", {16'b0, pc_out}, 32'h0);
    check_eq("rst_pc_ff", {16'b0, pc_out_f}, 32'hFFFF);

    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset(16'h0000);

    // Zero-wait fetch; the FFFF-reset instance must wrap to 0000 for its high byte.
    step(1, 1, 0, 16'h0);
    check_eq("ff_lo_addr", {16'b0, mem_addr_f}, 32'hFFFF);
    check_eq("ff_lo_req", {31'b0, mem_req_f}, 32'h1);
    step(1, 1, 0, 16'h0);
    check_eq("ff_hi_addr", {16'b0, mem_addr_f}, 32'h0000);
    step(1, 1, 0, 16'h0);
    check_eq("t1_valid", {31'b0, instr_valid}, 32'h1);
    check_eq("t1_ir", {16'b0, ir_q}, 32'h1234);
    check_eq("ff_valid", {31'b0, instr_valid_f}, 32'h1);
    check_eq("ff_pc_issue", {16'b0, pc_out_f}, 32'hFFFF);
    step(1, 1, 0, 16'h0);
    check_eq("t1_next_addr", {16'b0, mem_addr}, 32'h0002);
    check_eq("ff_pc_next", {16'b0, pc_out_f}, 32'h0001);

    // Two wait cycles on each byte.
    e0 = e_count;
    step(0, 1, 0, 16'h0); step(0, 1, 0, 16'h0); step(1, 1, 0, 16'h0);
    step(0, 1, 0, 16'h0); step(0, 1, 0, 16'h0); step(1, 1, 0, 16'h0);
    check_eq("t2_valid", {31'b0, instr_valid}, 32'h1);
    check_eq("t2_ir_e_pulses", 32'(e_count - e0), 32'd2);

    // Decode stalls for five cycles.
    for (int i = 0; i < 5; i++) step(0, 0, 0, 16'h0);
    check_eq("t3_pc_held", {16'b0, pc_out}, 32'h0002);
    step(1, 1, 0, 16'h0);

    // Redirect coinciding with the high-byte ack.
    step(1, 1, 0, 16'h0);
    e0 = e_count;
    step(1, 1, 1, 16'h0040);
    check_eq("t4_no_ir_e", 32'(e_count - e0), 32'd0);
    check_eq("t4_addr", {16'b0, mem_addr}, 32'h0040);
    step(1, 1, 0, 16'h0);
    step(1, 1, 0, 16'h0);
    check_eq("t4_ir", {16'b0, ir_q}, {16'b0, mem[16'h41], mem[16'h40]});
    // Redirect beats a same-cycle consume.
    step(0, 1, 1, 16'h0100);
    check_eq("t4_redirect_pc", {16'b0, pc_out}, 32'h0100);

    // Asynchronous reset while waiting on the high byte.
    step(1, 1, 0, 16'h0);
    mem_ack = 1'b1; instr_ready = 1'b0; pc_load = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_req_drop", {31'b0, mem_req}, 32'h0);
    check_eq("t6_ir_e_drop", {31'b0, ir_e}, 32'h0);
    check_eq("t6_pc_reset", {16'b0, pc_out}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset(16'h0000);
    step(1, 1, 0, 16'h0);
    step(1, 1, 0, 16'h0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 100) < 65, ($urandom % 100) < 50, ($urandom % 100) < 4, 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
